multicycle_sequencer: RTL

Multicycle control sequencer for the single-issue MIPS datapath. Steps each instruction through fetch, decode, execute, memory and writeback. Takes its per-instruction decode from the control unit, whose inputs are driven from the latched instruction register. Issues the memory request strobes, register enables, PC-update and halt. Also keeps cycle and retired-instruction counters for the testbench.

---
 rtl/multicycle_sequencer.sv | 108 ++++++++++
 1 files changed

// File: rtl/multicycle_sequencer.sv
// Multicycle control sequencer: walks each instruction through fetch, decode,
// execute, memory and writeback, issuing memory/register/PC strobes and keeping counters.
module multicycle_sequencer #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             cu_halt,
  input  logic             cu_dREN,
  input  logic             cu_dWEN,
  input  logic             cu_RegWrite,
  output logic             imemREN,
  output logic             dmemREN,
  output logic             dmemWEN,
  output logic             ir_en,
  output logic             mdr_en,
  output logic             rf_wen,
  output logic             pc_en,
  output logic             halt,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] cycles,
  output logic [CNT_W-1:0] instret
);

  localparam logic [2:0] S_IFETCH = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEMACC = 3'd3;
  localparam logic [2:0] S_WBACK  = 3'd4;
  localparam logic [2:0] S_HALTED = 3'd5;

  logic [2:0]       state_reg, state_next;
  logic             halt_reg;
  logic [CNT_W-1:0] cycles_reg, instret_reg;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_reg   <= S_IFETCH;
      halt_reg    <= 1'b0;
      cycles_reg  <= '0;
      instret_reg <= '0;
    end else begin
      state_reg <= state_next;
      halt_reg  <= (state_next == S_HALTED);
      if (state_reg != S_HALTED && cycles_reg != '1)
        cycles_reg <= cycles_reg + 1'b1;
      // pc_en marks retirement of exactly one instruction
      if (pc_en && instret_reg != '1)
        instret_reg <= instret_reg + 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IFETCH: if (ihit) state_next = S_DECODE;
      S_DECODE: state_next = cu_halt ? S_HALTED : S_EXEC;
      S_EXEC: begin
        if (cu_dREN || cu_dWEN) state_next = S_MEMACC;
        else if (cu_RegWrite)   state_next = S_WBACK;
        else                    state_next = S_IFETCH;
      end
      S_MEMACC: if (dhit) state_next = cu_dREN ? S_WBACK : S_IFETCH;
      S_WBACK:  state_next = S_IFETCH;
      S_HALTED: state_next = S_HALTED;
      default:  state_next = S_IFETCH;
    endcase
  end

  // Strobes are suppressed while reset is asserted so a coincident hit has no effect.
  always_comb begin
    imemREN = 1'b0;
    dmemREN = 1'b0;
    dmemWEN = 1'b0;
    ir_en   = 1'b0;
    mdr_en  = 1'b0;
    rf_wen  = 1'b0;
    pc_en   = 1'b0;
    if (nRST) begin
      case (state_reg)
        S_IFETCH: begin
          imemREN = 1'b1;
          ir_en   = ihit;
        end
        S_EXEC: pc_en = ~(cu_dREN | cu_dWEN | cu_RegWrite);
        S_MEMACC: begin
          dmemREN = cu_dREN;
          dmemWEN = cu_dWEN & ~cu_dREN;
          mdr_en  = dhit & cu_dREN;
          pc_en   = dhit & ~cu_dREN;
        end
        S_WBACK: begin
          rf_wen = 1'b1;
          pc_en  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign halt    = halt_reg;
  assign state   = state_reg;
  assign cycles  = cycles_reg;
  assign instret = instret_reg;

endmodule
